// File: rtl/multi_alarm_clk_if.sv
// Control and status bundle between the time-setting/buzzer logic (master)
// and the multi-alarm real-time clock (slave).
interface multi_alarm_clk_if #(
    parameter int NUM_ALARMS = 4,
    parameter int SEL_W      = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
);
    logic                  LoadTime;
    logic                  Set_AM_PM;
    logic [5:0]            SetSecs;
    logic [5:0]            SetMins;
    logic [4:0]            SetHours;
    logic                  LoadAlm;
    logic [SEL_W-1:0]      AlmSel;
    logic [5:0]            AlarmMinsIn;
    logic [4:0]            AlarmHoursIn;
    logic                  Alarm_AM_PM_In;
    logic [NUM_ALARMS-1:0] AlarmEnable;
    logic                  Snooze;
    logic                  AlarmStop;
    logic [5:0]            Secs_C;
    logic [5:0]            Mins_C;
    logic [4:0]            Hours_C;
    logic                  AM_PM;
    logic                  Alarm;
    logic [SEL_W-1:0]      AlarmId;

    modport master (
        output LoadTime, Set_AM_PM, SetSecs, SetMins, SetHours,
        output LoadAlm, AlmSel, AlarmMinsIn, AlarmHoursIn, Alarm_AM_PM_In,
        output AlarmEnable, Snooze, AlarmStop,
        input  Secs_C, Mins_C, Hours_C, AM_PM, Alarm, AlarmId
    );

    modport slave (
        input  LoadTime, Set_AM_PM, SetSecs, SetMins, SetHours,
        input  LoadAlm, AlmSel, AlarmMinsIn, AlarmHoursIn, Alarm_AM_PM_In,
        input  AlarmEnable, Snooze, AlarmStop,
        output Secs_C, Mins_C, Hours_C, AM_PM, Alarm, AlarmId
    );
endinterface

// File: rtl/multi_alarm_clk.sv
// 12h/24h real-time clock on a 1 Hz clock with NUM_ALARMS alarm slots,
// a shared buzzer output, snooze and automatic ring timeout.
module multi_alarm_clk #(
    parameter int NUM_ALARMS  = 4,
    parameter int MODE_24H    = 0,
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_MINS = 9
) (
    input  logic              Clock_1Sec,
    input  logic              Reset,
    multi_alarm_clk_if.slave  bus
);
    localparam int          SEL_W       = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;
    localparam logic [4:0]  RESET_HOURS = (MODE_24H != 0) ? 5'd0 : 5'd12;
    localparam logic [7:0]  RING_LOAD   = 8'(RING_SECS - 1);
    localparam logic [11:0] SNOOZE_LOAD = 12'(SNOOZE_MINS * 60 - 1);

    typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} state_t;

    state_t           state;
    logic [7:0]       ring_cnt;
    logic [11:0]      snooze_cnt;
    logic             alarm;
    logic [SEL_W-1:0] alarm_id;

    logic [5:0] secs, mins;
    logic [4:0] hours;
    logic       pm;

    logic [5:0] alm_mins  [NUM_ALARMS];
    logic [4:0] alm_hours [NUM_ALARMS];
    logic       alm_pm    [NUM_ALARMS];

    logic [5:0]       next_secs, next_mins;
    logic [4:0]       next_hours;
    logic             next_pm;
    logic             time_ok, alm_ok, owner_hit;
    logic             match_found;
    logic [SEL_W-1:0] match_id;

    function automatic logic hours_valid(input logic [4:0] h);
        if (MODE_24H != 0) return h <= 5'd23;
        return (h >= 5'd1) && (h <= 5'd12);
    endfunction

    assign time_ok = bus.LoadTime && (bus.SetSecs <= 6'd59) && (bus.SetMins <= 6'd59)
                     && hours_valid(bus.SetHours);
    assign alm_ok  = bus.LoadAlm && (bus.AlarmMinsIn <= 6'd59) && hours_valid(bus.AlarmHoursIn)
                     && (32'(bus.AlmSel) < NUM_ALARMS);
    assign owner_hit = alm_ok && (bus.AlmSel == alarm_id);

    // The time the display will show after this edge if counting.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        next_secs  = secs + 6'd1;
        next_mins  = mins;
        next_hours = hours;
        next_pm    = pm;
        if (secs == 6'd59) begin
            next_secs = 6'd0;
            next_mins = mins + 6'd1;
            if (mins == 6'd59) begin
                next_mins = 6'd0;
                if (MODE_24H != 0) begin
                    next_hours = (hours == 5'd23) ? 5'd0 : hours + 5'd1;
                end else if (hours == 5'd12) begin
                    next_hours = 5'd1;
                end else begin
                    next_hours = hours + 5'd1;
                    if (hours == 5'd11) next_pm = ~pm;
                end
            end
        end
    end

    // Scan from the top down so the lowest matching slot is the one kept.
    always_comb begin
        match_found = 1'b0;
        match_id    = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (bus.AlarmEnable[i] && (next_secs == 6'd0) && (next_mins == alm_mins[i])
                && (next_hours == alm_hours[i]) && ((MODE_24H != 0) || (next_pm == alm_pm[i]))) begin
                match_found = 1'b1;
                match_id    = SEL_W'(i);
            end
        end
    end

    always_ff @(posedge Clock_1Sec or negedge Reset) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (!Reset) begin
            secs  <= 6'd0;
            mins  <= 6'd0;
            hours <= RESET_HOURS;
            pm    <= 1'b0;
        end else if (time_ok) begin
            secs  <= bus.SetSecs;
            mins  <= bus.SetMins;
            hours <= bus.SetHours;
            pm    <= (MODE_24H != 0) ? 1'b0 : bus.Set_AM_PM;
        end else begin
            secs  <= next_secs;
            mins  <= next_mins;
            hours <= next_hours;
            pm    <= next_pm;
        end
    end

    // NOTE: the slot array must read 12:00 AM after reset, so it is built from resettable flops, not RAM.
    always_ff @(posedge Clock_1Sec or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                alm_mins[i]  <= 6'd0;
                alm_hours[i] <= RESET_HOURS;
                alm_pm[i]    <= 1'b0;
            end
        end else if (alm_ok) begin
            alm_mins[bus.AlmSel]  <= bus.AlarmMinsIn;
            alm_hours[bus.AlmSel] <= bus.AlarmHoursIn;
            alm_pm[bus.AlmSel]    <= (MODE_24H != 0) ? 1'b0 : bus.Alarm_AM_PM_In;
        end
    end

    always_ff @(posedge Clock_1Sec or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            alarm      <= 1'b0;
            alarm_id   <= '0;
            ring_cnt   <= 8'd0;
            snooze_cnt <= 12'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (match_found && !bus.LoadTime) begin
                        state    <= RINGING;
                        alarm    <= 1'b1;
                        alarm_id <= match_id;
                        ring_cnt <= RING_LOAD;
                    end
                end
                RINGING, SNOOZED: begin
                    // Dismissal sources outrank snooze and the countdowns.
                    if (owner_hit || !bus.AlarmEnable[alarm_id] || bus.AlarmStop) begin
                        state <= IDLE;
                        alarm <= 1'b0;
                    end else if (state == RINGING) begin
                        if (bus.Snooze) begin
                            state      <= SNOOZED;
                            alarm      <= 1'b0;
                            snooze_cnt <= SNOOZE_LOAD;
                        end else if (ring_cnt == 8'd0) begin
                            state <= IDLE;
                            alarm <= 1'b0;
                        end else begin
                            ring_cnt <= ring_cnt - 8'd1;
                        end
                    end else if (snooze_cnt == 12'd0) begin
                        state    <= RINGING;
                        alarm    <= 1'b1;
                        ring_cnt <= RING_LOAD;
                    end else begin
                        snooze_cnt <= snooze_cnt - 12'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    alarm <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Secs_C  = secs;
    assign bus.Mins_C  = mins;
    assign bus.Hours_C = hours;
    assign bus.AM_PM   = pm;
    assign bus.Alarm   = alarm;
    assign bus.AlarmId = alarm_id;
endmodule

// File: tb/tb_multi_alarm_clk.sv
// Bench for multi_alarm_clk: a 12h/60s/9min instance (A) and a 24h/3s/1min
// instance (B) driven identically and compared against a seconds-of-day model.
module tb_multi_alarm_clk;
    localparam int NA       = 4;
    localparam int ST_IDLE  = 0;
    localparam int ST_RING  = 1;
    localparam int ST_SNZ   = 2;
    localparam int MODE24   [2] = '{0, 1};
    localparam int RING_LEN [2] = '{60, 3};
    localparam int SNZ_LEN  [2] = '{540, 60};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multi_alarm_clk_if #(.NUM_ALARMS(NA)) bus_a ();
    multi_alarm_clk_if #(.NUM_ALARMS(NA)) bus_b ();

    multi_alarm_clk #(.NUM_ALARMS(NA), .MODE_24H(0), .RING_SECS(60), .SNOOZE_MINS(9)) dut_a (
        .Clock_1Sec(clk), .Reset(rst), .bus(bus_a));
    multi_alarm_clk #(.NUM_ALARMS(NA), .MODE_24H(1), .RING_SECS(3), .SNOOZE_MINS(1)) dut_b (
        .Clock_1Sec(clk), .Reset(rst), .bus(bus_b));

    typedef struct packed {
        logic       load_time;
        logic       set_pm;
        logic [5:0] set_secs;
        logic [5:0] set_mins;
        logic [4:0] set_hours;
        logic       load_alm;
        logic [1:0] sel;
        logic [5:0] alm_mins;
        logic [4:0] alm_hours;
        logic       alm_pm;
        logic [3:0] enable;
        logic       snooze;
        logic       stop;
    } stim_t;

    typedef struct {
        logic       lt;
        logic [4:0] h;
        logic [5:0] mi;
        logic [5:0] se;
        logic       pm;
        int         eh, em, es, epm;
    } vec_t;

    stim_t s;
    int    checks   = 0;
    int    failures = 0;
    int    edge_no  = 0;

    // Reference model: time as seconds since midnight, alarms as minute of day,
    // ring/snooze ends as absolute edge numbers.
    int m_t       [2];
    int m_alm     [2][NA];
    int m_st      [2];
    int m_owner   [2];
    int m_ring_end[2];
    int m_wake    [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_no);
        end
    endtask

    function automatic bit hours_ok(input int h, input int md);
        return (md != 0) ? (h <= 23) : (h >= 1 && h <= 12);
    endfunction

    function automatic int to_h24(input int h, input int pm, input int md);
        return (md != 0) ? h : (h % 12) + (pm != 0 ? 12 : 0);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_t[k] = 0;
            for (int i = 0; i < NA; i++) m_alm[k][i] = 0;
            m_st[k] = ST_IDLE;
            m_owner[k] = 0;
            m_ring_end[k] = 0;
            m_wake[k] = 0;
        end
    endtask

    task automatic model_step(input int k);
        int nt;
        bit alm_wr, hit;
        nt     = (m_t[k] + 1) % 86400;
        alm_wr = s.load_alm && (int'(s.alm_mins) <= 59) && hours_ok(int'(s.alm_hours), MODE24[k]);
        if (m_st[k] != ST_IDLE) begin
            if ((alm_wr && int'(s.sel) == m_owner[k]) || !s.enable[m_owner[k]] || s.stop) begin
                m_st[k] = ST_IDLE;
            end else if (m_st[k] == ST_RING) begin
                if (s.snooze) begin
                    m_st[k]   = ST_SNZ;
                    m_wake[k] = edge_no + SNZ_LEN[k];
                end else if (edge_no == m_ring_end[k]) begin
                    m_st[k] = ST_IDLE;
                end
            end else if (edge_no == m_wake[k]) begin
                m_st[k]       = ST_RING;
                m_ring_end[k] = edge_no + RING_LEN[k];
            end
        end else if (!s.load_time && (nt % 60 == 0)) begin
            hit = 1'b0;
            for (int i = 0; i < NA; i++) begin
                if (!hit && s.enable[i] && m_alm[k][i] == nt / 60) begin
                    hit           = 1'b1;
                    m_st[k]       = ST_RING;
                    m_owner[k]    = i;
                    m_ring_end[k] = edge_no + RING_LEN[k];
                end
            end
        end
        if (s.load_time && int'(s.set_secs) <= 59 && int'(s.set_mins) <= 59
            && hours_ok(int'(s.set_hours), MODE24[k]))
            m_t[k] = to_h24(int'(s.set_hours), int'(s.set_pm), MODE24[k]) * 3600
                     + int'(s.set_mins) * 60 + int'(s.set_secs);
        else
            m_t[k] = nt;
        if (alm_wr)
            m_alm[k][s.sel] = to_h24(int'(s.alm_hours), int'(s.alm_pm), MODE24[k]) * 60
                              + int'(s.alm_mins);
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            int          h24, eh, epm;
            string       n;
            logic [31:0] a_s, a_m, a_h, a_p, a_al, a_id;
            n   = (k == 0) ? "A" : "B";
            h24 = m_t[k] / 3600;
            eh  = (MODE24[k] != 0) ? h24 : ((h24 % 12 == 0) ? 12 : h24 % 12);
            epm = (MODE24[k] == 0 && h24 >= 12) ? 1 : 0;
            if (k == 0) begin
                a_s = 32'(bus_a.Secs_C); a_m = 32'(bus_a.Mins_C); a_h = 32'(bus_a.Hours_C);
                a_p = 32'(bus_a.AM_PM);  a_al = 32'(bus_a.Alarm); a_id = 32'(bus_a.AlarmId);
            end else begin
                a_s = 32'(bus_b.Secs_C); a_m = 32'(bus_b.Mins_C); a_h = 32'(bus_b.Hours_C);
                a_p = 32'(bus_b.AM_PM);  a_al = 32'(bus_b.Alarm); a_id = 32'(bus_b.AlarmId);
            end
            check({n, " model secs"},  a_s,  m_t[k] % 60);
            check({n, " model mins"},  a_m,  (m_t[k] / 60) % 60);
            check({n, " model hours"}, a_h,  eh);
            check({n, " model am_pm"}, a_p,  epm);
            check({n, " model alarm"}, a_al, (m_st[k] == ST_RING) ? 1 : 0);
            check({n, " model id"},    a_id, m_owner[k]);
        end
    endtask

    task automatic apply();
        bus_a.LoadTime = s.load_time;   bus_b.LoadTime = s.load_time;
        bus_a.Set_AM_PM = s.set_pm;     bus_b.Set_AM_PM = s.set_pm;
        bus_a.SetSecs = s.set_secs;     bus_b.SetSecs = s.set_secs;
        bus_a.SetMins = s.set_mins;     bus_b.SetMins = s.set_mins;
        bus_a.SetHours = s.set_hours;   bus_b.SetHours = s.set_hours;
        bus_a.LoadAlm = s.load_alm;     bus_b.LoadAlm = s.load_alm;
        bus_a.AlmSel = s.sel;           bus_b.AlmSel = s.sel;
        bus_a.AlarmMinsIn = s.alm_mins; bus_b.AlarmMinsIn = s.alm_mins;
        bus_a.AlarmHoursIn = s.alm_hours;   bus_b.AlarmHoursIn = s.alm_hours;
        bus_a.Alarm_AM_PM_In = s.alm_pm;    bus_b.Alarm_AM_PM_In = s.alm_pm;
        bus_a.AlarmEnable = s.enable;   bus_b.AlarmEnable = s.enable;
        bus_a.Snooze = s.snooze;        bus_b.Snooze = s.snooze;
        bus_a.AlarmStop = s.stop;       bus_b.AlarmStop = s.stop;
    endtask

    task automatic tick();
        apply();
        @(posedge clk);
        model_step(0);
        model_step(1);
        edge_no++;
        @(negedge clk);
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic load_time(input int h, input int mi, input int se, input int pm);
        s.load_time = 1'b1;
        s.set_hours = 5'(h); s.set_mins = 6'(mi); s.set_secs = 6'(se); s.set_pm = pm[0];
        tick();
        s.load_time = 1'b0;
    endtask

    task automatic load_alarm(input int sel, input int h, input int mi, input int pm);
        s.load_alm = 1'b1;
        s.sel = 2'(sel); s.alm_hours = 5'(h); s.alm_mins = 6'(mi); s.alm_pm = pm[0];
        tick();
        s.load_alm = 1'b0;
    endtask

    vec_t tbl [18];
    int   hr_set [5] = '{1, 2, 12, 13, 0};

    initial begin
        tbl[0]  = '{1'b1, 5'd11, 6'd59, 6'd59, 1'b0, 11, 59, 59, 0};
        tbl[1]  = '{1'b0, 5'd0,  6'd0,  6'd0,  1'b0, 12,  0,  0, 1};
        tbl[2]  = '{1'b1, 5'd12, 6'd59, 6'd59, 1'b1, 12, 59, 59, 1};
        tbl[3]  = '{1'b0, 5'd0,  6'd0,  6'd0,  1'b0,  1,  0,  0, 1};
        tbl[4]  = '{1'b1, 5'd11, 6'd59, 6'd59, 1'b1, 11, 59, 59, 1};
        tbl[5]  = '{1'b0, 5'd0,  6'd0,  6'd0,  1'b0, 12,  0,  0, 0};
        tbl[6]  = '{1'b1, 5'd12, 6'd59, 6'd59, 1'b0, 12, 59, 59, 0};
        tbl[7]  = '{1'b0, 5'd0,  6'd0,  6'd0,  1'b0,  1,  0,  0, 0};
        tbl[8]  = '{1'b1, 5'd5,  6'd60, 6'd0,  1'b0,  1,  0,  1, 0};
        tbl[9]  = '{1'b1, 5'd13, 6'd10, 6'd10, 1'b0,  1,  0,  2, 0};
        tbl[10] = '{1'b1, 5'd0,  6'd10, 6'd10, 1'b0,  1,  0,  3, 0};
        tbl[11] = '{1'b1, 5'd5,  6'd10, 6'd60, 1'b0,  1,  0,  4, 0};
        tbl[12] = '{1'b1, 5'd9,  6'd15, 6'd30, 1'b1,  9, 15, 30, 1};
        tbl[13] = '{1'b0, 5'd0,  6'd0,  6'd0,  1'b0,  9, 15, 31, 1};
        tbl[14] = '{1'b1, 5'd10, 6'd59, 6'd59, 1'b0, 10, 59, 59, 0};
        tbl[15] = '{1'b0, 5'd0,  6'd0,  6'd0,  1'b0, 11,  0,  0, 0};
        tbl[16] = '{1'b1, 5'd3,  6'd45, 6'd59, 1'b1,  3, 45, 59, 1};
        tbl[17] = '{1'b0, 5'd0,  6'd0,  6'd0,  1'b0,  3, 46,  0, 1};

        s = '0;
        apply();
        #1 rst = 1'b0;
        model_reset();
        #3;
        check_all();
        check("reset A hours", 32'(bus_a.Hours_C), 12);
        check("reset B hours", 32'(bus_b.Hours_C), 0);
        @(negedge clk);
        rst = 1'b1;

        // Time counting, wrap and load rejection against fixed expectations.
        for (int i = 0; i < 18; i++) begin
            s.load_time = tbl[i].lt;
            s.set_hours = tbl[i].h; s.set_mins = tbl[i].mi;
            s.set_secs  = tbl[i].se; s.set_pm  = tbl[i].pm;
            tick();
            check($sformatf("tbl%0d hours", i), 32'(bus_a.Hours_C), tbl[i].eh);
            check($sformatf("tbl%0d mins", i),  32'(bus_a.Mins_C),  tbl[i].em);
            check($sformatf("tbl%0d secs", i),  32'(bus_a.Secs_C),  tbl[i].es);
            check($sformatf("tbl%0d am_pm", i), 32'(bus_a.AM_PM),   tbl[i].epm);
        end
        s.load_time = 1'b0;

        load_time(23, 59, 59, 0);
        tick();
        check("24h wrap hours", 32'(bus_b.Hours_C), 0);
        check("24h wrap secs",  32'(bus_b.Secs_C),  0);

        // Basic ring: exactly 60 high edges.
        load_alarm(0, 7, 30, 0);
        s.enable = 4'b0001;
        load_time(7, 29, 58, 0);
        tick();
        check("ring pre", 32'(bus_a.Alarm), 0);
        tick();
        check("ring rise", 32'(bus_a.Alarm), 1);
        check("ring id",   32'(bus_a.AlarmId), 0);
        check("ring mins", 32'(bus_a.Mins_C), 30);
        for (int i = 0; i < 59; i++) begin
            tick();
            check("ring hold", 32'(bus_a.Alarm), 1);
        end
        tick();
        check("ring timeout", 32'(bus_a.Alarm), 0);

        // Simultaneous match: lowest slot wins, higher one is dropped.
        load_alarm(1, 6, 0, 1);
        load_alarm(3, 6, 0, 1);
        s.enable = 4'b1010;
        load_time(5, 59, 59, 1);
        tick();
        check("tie alarm", 32'(bus_a.Alarm), 1);
        check("tie id",    32'(bus_a.AlarmId), 1);
        s.stop = 1'b1;
        tick();
        s.stop = 1'b0;
        check("tie stop", 32'(bus_a.Alarm), 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("tie dropped", 32'(bus_a.Alarm), 0);
        end

        // Snooze at 07:30:05, re-ring at 07:39:05; snooze while snoozed ignored.
        s.enable = 4'b0001;
        load_time(7, 29, 59, 0);
        tick();
        run(4);
        s.snooze = 1'b1;
        tick();
        s.snooze = 1'b0;
        check("snooze off",  32'(bus_a.Alarm), 0);
        check("snooze secs", 32'(bus_a.Secs_C), 5);
        run(200);
        s.snooze = 1'b1;
        tick();
        s.snooze = 1'b0;
        run(338);
        check("snooze wait", 32'(bus_a.Alarm), 0);
        tick();
        check("rering alarm", 32'(bus_a.Alarm), 1);
        check("rering id",    32'(bus_a.AlarmId), 0);
        check("rering mins",  32'(bus_a.Mins_C), 39);
        check("rering secs",  32'(bus_a.Secs_C), 5);

        // Stop beats snooze: no re-ring afterwards.
        s.snooze = 1'b1;
        s.stop = 1'b1;
        tick();
        s.snooze = 1'b0;
        s.stop = 1'b0;
        check("stop+snooze", 32'(bus_a.Alarm), 0);
        for (int i = 0; i < 600; i++) begin
            tick();
            check("no rering", 32'(bus_a.Alarm), 0);
        end

        // Enable dropped mid-ring, then time load mid-ring.
        load_time(7, 29, 59, 0);
        tick();
        s.enable = 4'b0000;
        tick();
        check("disable stops", 32'(bus_a.Alarm), 0);
        s.enable = 4'b0001;
        load_time(7, 29, 59, 0);
        tick();
        load_time(1, 2, 3, 1);
        check("load mid ring alarm", 32'(bus_a.Alarm), 1);
        check("load mid ring hours", 32'(bus_a.Hours_C), 1);

        // Asynchronous reset mid-ring, away from any clock edge.
        #2 rst = 1'b0;
        model_reset();
        #1;
        check("async rst hours", 32'(bus_a.Hours_C), 12);
        check("async rst mins",  32'(bus_a.Mins_C), 0);
        check("async rst secs",  32'(bus_a.Secs_C), 0);
        check("async rst am_pm", 32'(bus_a.AM_PM), 0);
        check("async rst alarm", 32'(bus_a.Alarm), 0);
        check("async rst id",    32'(bus_a.AlarmId), 0);
        check("async rst B hrs", 32'(bus_b.Hours_C), 0);
        @(negedge clk);
        rst = 1'b1;
        check_all();

        // Randomised traffic biased toward alarm boundaries.
        for (int it = 0; it < 3000; it++) begin
            s.load_time = 1'b0;
            s.load_alm  = 1'b0;
            s.snooze    = ($urandom_range(0, 7) == 0);
            s.stop      = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 29) == 0) begin
                s.load_time = 1'b1;
                s.set_hours = 5'(hr_set[$urandom_range(0, 4)]);
                s.set_mins  = 6'($urandom_range(0, 3));
                s.set_secs  = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63))
                                                          : 6'($urandom_range(50, 59));
                s.set_pm    = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 24) == 0) begin
                s.load_alm  = 1'b1;
                s.sel       = 2'($urandom_range(0, 3));
                s.alm_hours = 5'(hr_set[$urandom_range(0, 4)]);
                s.alm_mins  = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63))
                                                          : 6'($urandom_range(0, 4));
                s.alm_pm    = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 49) == 0) s.enable = 4'($urandom_range(0, 15));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
